lc4_issue_queue_ooo: RTL and testbench

- Parametrised, stateful issue queue for the LC4 out-of-order core. Sits between rename/dispatch and the ALU/load execute ports.
- Buffers DEPTH renamed instructions and wakes source operands from WB_CH tag-broadcast channels.
- Each cycle, selects the oldest fully-ready entry into a registered issue slot with a stall handshake.
- Generalises the fixed 4-entry, fixed-channel combinational issue select into a collapsing, age-ordered buffer.

---
 rtl/lc4_issue_queue_ooo.sv | 174 +++++++++++++++++
 tb/tb_lc4_issue_queue_ooo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc4_issue_queue_ooo.sv
// LC4 out-of-order issue queue: collapsing age-ordered buffer with tag wakeup and a stallable issue slot.
// Optional perf counters are built when LC4_IQ_PERF_CTR_EN is defined.
module lc4_issue_queue_ooo #(
    parameter int DEPTH     = 8,
    parameter int PREG_BITS = 4,
    parameter int ROB_BITS  = 3,
    parameter int WB_CH     = 4,
    parameter int PAYLOAD_W = 48,
    localparam int CNT_W    = $clog2(DEPTH + 1),
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       dp_valid,
    output logic                       dp_ready,
    input  logic [PAYLOAD_W-1:0]       dp_payload,
    input  logic [PREG_BITS-1:0]       dp_pr1,
    input  logic [PREG_BITS-1:0]       dp_pr2,
    input  logic [PREG_BITS-1:0]       dp_prd,
    input  logic                       dp_r1_rdy,
    input  logic                       dp_r2_rdy,
    input  logic [ROB_BITS-1:0]        dp_rob_idx,
    input  logic [WB_CH-1:0]           wk_valid,
    input  logic [WB_CH*PREG_BITS-1:0] wk_prd,
    output logic                       is_valid,
    input  logic                       is_stall,
    output logic [PAYLOAD_W-1:0]       is_payload,
    output logic [PREG_BITS-1:0]       is_pr1sel,
    output logic [PREG_BITS-1:0]       is_pr2sel,
    output logic [PREG_BITS-1:0]       is_prd,
    output logic [ROB_BITS-1:0]        is_rob_index,
    output logic [CNT_W-1:0]           iq_count,
    output logic [15:0]                perf_issue_cnt,
    output logic [15:0]                perf_full_cnt
);

    typedef struct packed {
        logic [PAYLOAD_W-1:0] pl;
        logic [PREG_BITS-1:0] pr1;
        logic [PREG_BITS-1:0] pr2;
        logic [PREG_BITS-1:0] prd;
        logic [ROB_BITS-1:0]  rob;
        logic                 r1;
        logic                 r2;
    } ent_t;

    function automatic logic wake(input logic [PREG_BITS-1:0]       tag,
                                  input logic [WB_CH-1:0]           v,
                                  input logic [WB_CH*PREG_BITS-1:0] t);
        wake = 1'b0;
        for (int k = 0; k < WB_CH; k++)
            if (v[k] && t[k*PREG_BITS +: PREG_BITS] == tag) wake = 1'b1;
    endfunction

    ent_t                 ent_q [DEPTH];
    ent_t                 ent_w [DEPTH];
    ent_t                 ent_s [DEPTH];
    ent_t                 ent_d [DEPTH];
    ent_t                 dp_ent;
    logic [DEPTH-1:0]     elig;
    logic                 any_elig;
    logic [IDX_W-1:0]     sel_idx;
    logic                 adv, take, dp_acc;
    logic [CNT_W-1:0]     count_q, count_d, count_after;

    logic                 is_valid_q;
    logic [PAYLOAD_W-1:0] is_pl_q;
    logic [PREG_BITS-1:0] is_pr1_q, is_pr2_q, is_prd_q;
    logic [ROB_BITS-1:0]  is_rob_q;

    assign dp_ready = (count_q < CNT_W'(DEPTH));
    assign adv      = !is_valid_q || !is_stall;
    assign take     = adv && any_elig;
    assign dp_acc   = dp_valid && dp_ready;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_w[i]    = ent_q[i];
            ent_w[i].r1 = ent_q[i].r1 | wake(ent_q[i].pr1, wk_valid, wk_prd);
            ent_w[i].r2 = ent_q[i].r2 | wake(ent_q[i].pr2, wk_valid, wk_prd);
            elig[i]     = (CNT_W'(i) < count_q) && ent_w[i].r1 && ent_w[i].r2;
        end
        any_elig = 1'b0;
        sel_idx  = '0;
        // Scan downward so the oldest eligible entry wins.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                any_elig = 1'b1;
                sel_idx  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        dp_ent.pl   = dp_payload;
        dp_ent.pr1  = dp_pr1;
        dp_ent.pr2  = dp_pr2;
        dp_ent.prd  = dp_prd;
        dp_ent.rob  = dp_rob_idx;
        dp_ent.r1   = dp_r1_rdy | wake(dp_pr1, wk_valid, wk_prd);
        dp_ent.r2   = dp_r2_rdy | wake(dp_pr2, wk_valid, wk_prd);
        count_after = count_q - CNT_W'(take);
        count_d     = count_after + CNT_W'(dp_acc);
        for (int i = 0; i < DEPTH - 1; i++) ent_s[i] = ent_w[i + 1];
        ent_s[DEPTH-1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = (take && IDX_W'(i) >= sel_idx) ? ent_s[i] : ent_w[i];
            // New entry lands at the tail that remains after this cycle's removal.
            if (dp_acc && CNT_W'(i) == count_after) ent_d[i] = dp_ent;
        end
    end

    // Entry contents are qualified by count_q, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            is_valid_q <= 1'b0;
            is_pl_q    <= '0;
            is_pr1_q   <= '0;
            is_pr2_q   <= '0;
            is_prd_q   <= '0;
            is_rob_q   <= '0;
        end else if (flush) begin
            count_q    <= '0;
            is_valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (adv) begin
                is_valid_q <= any_elig;
                if (any_elig) begin
                    is_pl_q  <= ent_w[sel_idx].pl;
                    is_pr1_q <= ent_w[sel_idx].pr1;
                    is_pr2_q <= ent_w[sel_idx].pr2;
                    is_prd_q <= ent_w[sel_idx].prd;
                    is_rob_q <= ent_w[sel_idx].rob;
                end
            end
        end
    end

    assign is_valid     = is_valid_q;
    assign is_payload   = is_pl_q;
    assign is_pr1sel    = is_pr1_q;
    assign is_pr2sel    = is_pr2_q;
    assign is_prd       = is_prd_q;
    assign is_rob_index = is_rob_q;
    assign iq_count     = count_q;

`ifdef LC4_IQ_PERF_CTR_EN
    logic [15:0] perf_issue_q, perf_full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_full_q  <= '0;
        end else begin
            if (take && !flush && perf_issue_q != 16'hFFFF) perf_issue_q <= perf_issue_q + 16'd1;
            if (count_q == CNT_W'(DEPTH) && perf_full_q != 16'hFFFF) perf_full_q <= perf_full_q + 16'd1;
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_full_cnt  = perf_full_q;
`else
    assign perf_issue_cnt = 16'h0000;
    assign perf_full_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_lc4_issue_queue_ooo.sv
// Scoreboard bench for lc4_issue_queue_ooo: expected issue order is queued by the stimulus, a negedge monitor checks each handshake.
module tb_lc4_issue_queue_ooo;

    logic        clk, rst, flush;
    logic        dp_valid, dp_ready;
    logic [47:0] dp_payload;
    logic [3:0]  dp_pr1, dp_pr2, dp_prd;
    logic        dp_r1_rdy, dp_r2_rdy;
    logic [2:0]  dp_rob_idx;
    logic [3:0]  wk_valid;
    logic [15:0] wk_prd;
    logic        is_valid, is_stall;
    logic [47:0] is_payload;
    logic [3:0]  is_pr1sel, is_pr2sel, is_prd;
    logic [2:0]  is_rob_index;
    logic [3:0]  iq_count;
    logic [15:0] perf_issue_cnt, perf_full_cnt;

    lc4_issue_queue_ooo dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_payload(dp_payload),
        .dp_pr1(dp_pr1), .dp_pr2(dp_pr2), .dp_prd(dp_prd),
        .dp_r1_rdy(dp_r1_rdy), .dp_r2_rdy(dp_r2_rdy), .dp_rob_idx(dp_rob_idx),
        .wk_valid(wk_valid), .wk_prd(wk_prd),
        .is_valid(is_valid), .is_stall(is_stall), .is_payload(is_payload),
        .is_pr1sel(is_pr1sel), .is_pr2sel(is_pr2sel), .is_prd(is_prd),
        .is_rob_index(is_rob_index), .iq_count(iq_count),
        .perf_issue_cnt(perf_issue_cnt), .perf_full_cnt(perf_full_cnt)
    );

    typedef struct packed {
        logic [47:0] pl;
        logic [3:0]  pr1;
        logic [3:0]  pr2;
        logic [3:0]  prd;
        logic [2:0]  rob;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

`ifdef LC4_IQ_PERF_CTR_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [47:0] pl, input logic [3:0] p1, input logic [3:0] p2,
                        input logic [3:0] pd, input logic r1, input logic r2,
                        input logic [2:0] rob, input bit expect_issue);
        dp_valid   = 1'b1;
        dp_payload = pl;
        dp_pr1     = p1;
        dp_pr2     = p2;
        dp_prd     = pd;
        dp_r1_rdy  = r1;
        dp_r2_rdy  = r2;
        dp_rob_idx = rob;
        if (expect_issue) sb.push_back('{pl, p1, p2, pd, rob});
    endtask

    // Each cycle the slot is valid and not stalled is one instruction handed to execute.
    always @(negedge clk) begin
        if (!rst && is_valid && !is_stall) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue", {61'd0, is_rob_index}, 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("issue_fields", {1'b0, is_payload, is_pr1sel, is_pr2sel, is_prd, is_rob_index},
                    {1'b0, e});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; dp_valid = 1'b0; dp_payload = '0;
        dp_pr1 = '0; dp_pr2 = '0; dp_prd = '0; dp_r1_rdy = 1'b0; dp_r2_rdy = 1'b0;
        dp_rob_idx = '0; wk_valid = '0; wk_prd = '0; is_stall = 1'b0;
        tick(); tick();
        chk("rst_is_valid", {63'd0, is_valid}, 64'd0);
        chk("rst_count", {60'd0, iq_count}, 64'd0);
        chk("rst_dp_ready", {63'd0, dp_ready}, 64'd1);
        chk("rst_payload", {16'd0, is_payload}, 64'd0);
        chk("rst_perf", {32'd0, perf_issue_cnt, perf_full_cnt}, 64'd0);
        rst = 1'b0;

        // Back-to-back ready dispatches: two-edge latency, count peaks at 1.
        disp(48'hA00000000000, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 3'd0, 1'b1);
        tick();
        chk("s1_count_e1", {60'd0, iq_count}, 64'd1);
        chk("s1_valid_e1", {63'd0, is_valid}, 64'd0);
        disp(48'hA00000000001, 4'd1, 4'd2, 4'd4, 1'b1, 1'b1, 3'd1, 1'b1);
        tick();
        chk("s1_e2", {59'd0, is_valid, is_rob_index, 1'b0}, {59'd0, 1'b1, 3'd0, 1'b0});
        chk("s1_count_e2", {60'd0, iq_count}, 64'd1);
        disp(48'hA00000000002, 4'd1, 4'd2, 4'd5, 1'b1, 1'b1, 3'd2, 1'b1);
        tick();
        chk("s1_e3", {60'd0, is_valid, is_rob_index}, {60'd0, 1'b1, 3'd1});
        chk("s1_count_e3", {60'd0, iq_count}, 64'd1);
        dp_valid = 1'b0;
        tick();
        chk("s1_e4", {60'd0, is_valid, is_rob_index}, {60'd0, 1'b1, 3'd2});
        chk("s1_count_e4", {60'd0, iq_count}, 64'd0);
        tick();
        chk("s1_e5_idle", {63'd0, is_valid}, 64'd0);

        // Younger ready entry bypasses an older blocked one; wk_valid gates matching.
        wk_prd = 16'h5555; wk_valid = 4'b0000;
        disp(48'hB0000000000A, 4'd5, 4'd1, 4'd6, 1'b0, 1'b1, 3'd3, 1'b0);
        tick();
        disp(48'hB0000000000B, 4'd2, 4'd3, 4'd7, 1'b1, 1'b1, 3'd4, 1'b1);
        sb.push_back('{48'hB0000000000A, 4'd5, 4'd1, 4'd6, 3'd3});
        tick();
        chk("s2_e2_idle", {63'd0, is_valid}, 64'd0);
        chk("s2_count_e2", {60'd0, iq_count}, 64'd2);
        dp_valid = 1'b0;
        tick();
        chk("s2_b_first", {60'd0, is_valid, is_rob_index}, {60'd0, 1'b1, 3'd4});
        wk_valid = 4'b0100;
        tick();
        chk("s2_a_bypass", {56'd0, is_valid, is_rob_index, is_pr1sel}, {56'd0, 1'b1, 3'd3, 4'd5});
        chk("s2_count", {60'd0, iq_count}, 64'd0);
        wk_valid = 4'b0000;

        // Tag 0 wakes like any tag; stored ready bit plus bypass on the other source.
        disp(48'hC00000000000, 4'd0, 4'd7, 4'd8, 1'b0, 1'b0, 3'd5, 1'b1);
        tick();
        dp_valid = 1'b0;
        wk_valid = 4'b0001; wk_prd = 16'h0000;
        tick();
        chk("s2_tag0_wait", {59'd0, is_valid, iq_count}, {59'd0, 1'b0, 4'd1});
        wk_valid = 4'b0010; wk_prd = 16'h0070;
        tick();
        chk("s2_tag0_issue", {60'd0, is_valid, is_rob_index}, {60'd0, 1'b1, 3'd5});
        wk_valid = 4'b0000;
        tick();
        chk("s2_perf_issue", {48'd0, perf_issue_cnt}, PERF ? 64'd6 : 64'd0);

        // Fill with blocked entries, reject overflow, then drain in age order.
        for (int i = 0; i < 8; i++) begin
            disp(48'hD00000000000 + 48'(i), 4'd9, 4'd1, 4'(i), 1'b0, 1'b1, 3'(i), 1'b1);
            tick();
        end
        chk("s3_full_count", {60'd0, iq_count}, 64'd8);
        chk("s3_dp_ready", {63'd0, dp_ready}, 64'd0);
        disp(48'hDEADDEADDEAD, 4'd1, 4'd1, 4'd15, 1'b1, 1'b1, 3'd7, 1'b0);
        tick(); tick();
        chk("s3_ignored", {60'd0, iq_count}, 64'd8);
        chk("s3_perf_full", {48'd0, perf_full_cnt}, PERF ? 64'd2 : 64'd0);
        wk_valid = 4'b1000; wk_prd = 16'h9000;
        tick();
        chk("s3_full_no_accept", {60'd0, iq_count}, 64'd7);
        chk("s3_first_out", {60'd0, is_valid, is_rob_index}, {60'd0, 1'b1, 3'd0});
        wk_valid = 4'b0000; dp_valid = 1'b0;
        repeat (8) tick();
        chk("s3_drained", {59'd0, is_valid, iq_count}, 64'd0);

        // Stall holds the slot and leaves the eligible entry queued.
        is_stall = 1'b1;
        disp(48'h000000000111, 4'd3, 4'd4, 4'd10, 1'b1, 1'b1, 3'd1, 1'b1);
        tick();
        disp(48'h000000000222, 4'd3, 4'd4, 4'd11, 1'b1, 1'b1, 3'd2, 1'b1);
        tick();
        dp_valid = 1'b0;
        chk("s4_loaded", {56'd0, is_valid, is_rob_index, iq_count}, {56'd0, 1'b1, 3'd1, 4'd1});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s4_hold", {5'd0, is_payload, is_prd, is_rob_index, iq_count},
                {5'd0, 48'h000000000111, 4'd10, 3'd1, 4'd1});
        end
        is_stall = 1'b0;
        tick();
        chk("s4_release", {56'd0, is_valid, is_rob_index, iq_count}, {56'd0, 1'b1, 3'd2, 4'd0});
        tick();
        chk("s4_idle", {63'd0, is_valid}, 64'd0);

        // Flush with a stuck slot, five queued entries and a concurrent dispatch.
        is_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            disp(48'hE00000000000 + 48'(i), 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 3'(i), 1'b0);
            tick();
        end
        chk("s5_pre", {59'd0, is_valid, iq_count}, {59'd0, 1'b1, 4'd5});
        disp(48'hE000000000FF, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 3'd6, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0; dp_valid = 1'b0;
        chk("s5_flush", {58'd0, is_valid, dp_ready, iq_count}, {58'd0, 1'b0, 1'b1, 4'd0});
        is_stall = 1'b0;
        tick(); tick();
        chk("s5_discarded", {59'd0, is_valid, iq_count}, 64'd0);
        chk("s5_perf_keep", {32'd0, perf_issue_cnt, perf_full_cnt},
            PERF ? {32'd0, 16'd17, 16'd3} : 64'd0);

        // Reset mid-operation, then normal operation resumes.
        is_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            disp(48'hF00000000000 + 48'(i), 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 3'(i), 1'b0);
            tick();
        end
        dp_valid = 1'b0;
        chk("s6_pre", {59'd0, is_valid, iq_count}, {59'd0, 1'b1, 4'd4});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6_rst_slot", {4'd0, is_valid, is_payload, is_rob_index, iq_count}, 64'd0);
        chk("s6_rst_tags", {52'd0, is_pr1sel, is_pr2sel, is_prd}, 64'd0);
        chk("s6_rst_perf", {31'd0, dp_ready, perf_issue_cnt, perf_full_cnt}, {31'd0, 1'b1, 32'd0});
        is_stall = 1'b0;
        disp(48'h000000000777, 4'd1, 4'd2, 4'd12, 1'b1, 1'b1, 3'd3, 1'b1);
        tick();
        dp_valid = 1'b0;
        chk("s6_wait", {63'd0, is_valid}, 64'd0);
        tick();
        chk("s6_issue", {60'd0, is_valid, is_rob_index}, {60'd0, 1'b1, 3'd3});
        tick();
        chk("s6_idle", {63'd0, is_valid}, 64'd0);

        repeat (2) tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
